// File: rtl/ram_port_arbiter_if.sv
// One requester-side RAM port: request bundle in, grant and read response back.
interface ram_port_arbiter_if #(
   parameter int RAM_ADR_WIDTH = 6,
   parameter int DATA_WIDTH    = 16
);
   logic                     req;
   logic                     rw;
   logic                     lock;
   logic [RAM_ADR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0]    wdata;
   logic                     gnt;
   logic                     rvalid;
   logic [DATA_WIDTH-1:0]    rdata;

   modport master (output req, rw, lock, adr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, rw, lock, adr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for the shared single-port RAM: round-robin with bounded
// lock bursts and a boot mode in which port 0 owns the RAM exclusively.
module ram_port_arbiter #(
   parameter int RAM_ADR_WIDTH = 6,
   parameter int DATA_WIDTH    = 16,
   parameter int MAX_LOCK      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce,
   input  logic                     boot,
   ram_port_arbiter_if.slave        m0,
   ram_port_arbiter_if.slave        m1,
   output logic                     ram_enable,
   output logic                     ram_rw,
   output logic [RAM_ADR_WIDTH-1:0] ram_adr,
   output logic [DATA_WIDTH-1:0]    ram_in,
   input  logic [DATA_WIDTH-1:0]    ram_out
);

   localparam int LCW = $clog2(MAX_LOCK + 1);
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);
   localparam logic [LCW-1:0] LOCK_ONE = LCW'(1);
   // With MAX_LOCK==1 the first locked grant already exhausts the budget.
   localparam bit SINGLE_LOCK = (MAX_LOCK == 1);

   typedef enum logic [1:0] {ARB, HOLD0, HOLD1, BOOT} state_t;

   state_t         state_reg;
   logic           prio_reg;
   logic [LCW-1:0] lock_cnt_reg;
   logic           rvalid0_reg;
   logic           rvalid1_reg;

   logic           gnt0;
   logic           gnt1;
   logic           req1_ok;
   logic [LCW-1:0] lock_cnt_next;

   assign req1_ok = m1.req & ~boot;
   assign lock_cnt_next = (lock_cnt_reg >= LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + LOCK_ONE;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && ce) begin
         case (state_reg)
            ARB: begin
               if (m0.req && req1_ok) begin
                  gnt0 = ~prio_reg;
                  gnt1 = prio_reg;
               end else begin
                  gnt0 = m0.req;
                  gnt1 = req1_ok;
               end
            end
            HOLD0:   gnt0 = m0.req;
            HOLD1:   gnt1 = req1_ok;
            default: gnt0 = m0.req;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ARB;
         prio_reg     <= 1'b0;
         lock_cnt_reg <= '0;
         rvalid0_reg  <= 1'b0;
         rvalid1_reg  <= 1'b0;
      end else if (ce) begin
         rvalid0_reg <= gnt0 & ~m0.rw;
         rvalid1_reg <= gnt1 & ~m1.rw;
         if (boot) begin
            state_reg    <= BOOT;
            lock_cnt_reg <= '0;
         end else begin
            case (state_reg)
               ARB: begin
                  if (gnt0) begin
                     prio_reg <= 1'b1;
                     if (m0.lock && !(SINGLE_LOCK && m1.req)) begin
                        state_reg    <= HOLD0;
                        lock_cnt_reg <= LOCK_ONE;
                     end
                  end else if (gnt1) begin
                     prio_reg <= 1'b0;
                     if (m1.lock && !(SINGLE_LOCK && m0.req)) begin
                        state_reg    <= HOLD1;
                        lock_cnt_reg <= LOCK_ONE;
                     end
                  end
               end
               HOLD0: begin
                  if (!m0.req || !m0.lock || (lock_cnt_next == LOCK_MAX && m1.req)) begin
                     state_reg    <= ARB;
                     prio_reg     <= 1'b1;
                     lock_cnt_reg <= '0;
                  end else begin
                     lock_cnt_reg <= lock_cnt_next;
                  end
               end
               HOLD1: begin
                  if (!m1.req || !m1.lock || (lock_cnt_next == LOCK_MAX && m0.req)) begin
                     state_reg    <= ARB;
                     prio_reg     <= 1'b0;
                     lock_cnt_reg <= '0;
                  end else begin
                     lock_cnt_reg <= lock_cnt_next;
                  end
               end
               default: begin
                  // Leaving boot hands the first contested slot to the CPU side.
                  state_reg <= ARB;
                  prio_reg  <= 1'b1;
               end
            endcase
         end
      end
   end

   // A read return held through a ce=0 stretch shows up on the next enabled cycle.
   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = rvalid0_reg & ce;
   assign m1.rvalid = rvalid1_reg & ce;
   assign m0.rdata  = ram_out;
   assign m1.rdata  = ram_out;

   assign ram_enable = ce & (gnt0 | gnt1);

   always_comb begin
      ram_rw  = 1'b0;
      ram_adr = '0;
      ram_in  = '0;
      if (gnt0) begin
         ram_rw  = m0.rw;
         ram_adr = m0.adr;
         ram_in  = m0.wdata;
      end else if (gnt1) begin
         ram_rw  = m1.rw;
         ram_adr = m1.adr;
         ram_in  = m1.wdata;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scoreboard bench for ram_port_arbiter: stimulus queues expected
// grants and read returns, a negedge monitor pops and compares them.
module tb_ram_port_arbiter;
   localparam int AW = 6;
   localparam int DW = 16;
   localparam int NONE = 0;
   localparam int P0 = 1;
   localparam int P1 = 2;

   typedef struct {
      int            cyc;
      int            port;
      logic          rw;
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0;
   logic          boot = 1'b0;
   logic          ram_enable;
   logic          ram_rw;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_in;
   logic [DW-1:0] ram_out = '0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int   cycle = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t gq[$];
   exp_t rq[$];

   ram_port_arbiter_if #(.RAM_ADR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
   ram_port_arbiter_if #(.RAM_ADR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

   ram_port_arbiter #(.RAM_ADR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .boot       (boot),
      .m0         (m0_if),
      .m1         (m1_if),
      .ram_enable (ram_enable),
      .ram_rw     (ram_rw),
      .ram_adr    (ram_adr),
      .ram_in     (ram_in),
      .ram_out    (ram_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Registered single-port RAM model.
   always @(posedge clk) begin
      if (ram_enable) begin
         if (ram_rw) mem[ram_adr] <= ram_in;
         else        ram_out <= mem[ram_adr];
      end
   end

   // Monitor
   always @(negedge clk) begin
      logic g0, g1;
      exp_t e;
      int   ap;
      logic [DW-1:0] ad;
      g0 = m0_if.gnt;
      g1 = m1_if.gnt;

      checks++;
      if ((g0 & g1) || ((!ce || !rst_n) && (g0 | g1)) || (boot & g1) ||
          (ram_enable != (g0 | g1)) || (!rst_n && ram_rw) ||
          (m0_if.rvalid & m1_if.rvalid)) begin
         failures++;
         $display("FAIL invariant cycle=%0d gnt0=%b gnt1=%b ram_enable=%b ram_rw=%b ce=%b boot=%b rst_n=%b rvalid0=%b rvalid1=%b",
                  cycle, g0, g1, ram_enable, ram_rw, ce, boot, rst_n, m0_if.rvalid, m1_if.rvalid);
      end

      while (gq.size() > 0 && gq[0].cyc < cycle) begin
         e = gq.pop_front();
         checks++;
         failures++;
         $display("FAIL missed_grant cycle=%0d actual=no_grant required=port%0d", e.cyc, e.port);
      end
      if (g0 | g1) begin
         checks++;
         ap = g1 ? 1 : 0;
         if (gq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant cycle=%0d actual=port%0d required=no_grant", cycle, ap);
         end else begin
            e = gq.pop_front();
            if (e.cyc != cycle || e.port != ap || ram_rw != e.rw || ram_adr != e.adr ||
                (e.rw && ram_in != e.data)) begin
               failures++;
               $display("FAIL grant cycle=%0d actual=port%0d rw=%b adr=%0d in=%h required=cycle%0d port%0d rw=%b adr=%0d in=%h",
                        cycle, ap, ram_rw, ram_adr, ram_in, e.cyc, e.port, e.rw, e.adr, e.data);
            end else begin
               $display("txn grant cycle=%0d port=%0d rw=%b adr=%0d data=%h", cycle, ap, ram_rw, ram_adr, ram_in);
            end
         end
      end

      while (rq.size() > 0 && rq[0].cyc < cycle) begin
         e = rq.pop_front();
         checks++;
         failures++;
         $display("FAIL missed_rvalid cycle=%0d actual=no_rvalid required=port%0d", e.cyc, e.port);
      end
      if (m0_if.rvalid | m1_if.rvalid) begin
         checks++;
         ap = m1_if.rvalid ? 1 : 0;
         ad = m1_if.rvalid ? m1_if.rdata : m0_if.rdata;
         if (rq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid cycle=%0d actual=port%0d required=none", cycle, ap);
         end else begin
            e = rq.pop_front();
            if (e.cyc != cycle || e.port != ap || ad !== e.data) begin
               failures++;
               $display("FAIL rvalid cycle=%0d actual=port%0d data=%h required=cycle%0d port%0d data=%h",
                        cycle, ap, ad, e.cyc, e.port, e.data);
            end else begin
               $display("txn rvalid cycle=%0d port=%0d data=%h", cycle, ap, ad);
            end
         end
      end
   end

   task automatic set0(input logic r, input logic rw, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m0_if.req = r; m0_if.rw = rw; m0_if.lock = lk; m0_if.adr = a; m0_if.wdata = d;
   endtask

   task automatic set1(input logic r, input logic rw, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m1_if.req = r; m1_if.rw = rw; m1_if.lock = lk; m1_if.adr = a; m1_if.wdata = d;
   endtask

   task automatic idle();
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      set1(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // One clock cycle: expected grant port and expected read return for this cycle.
   task automatic cyc(input logic c, input logic b, input int eg, input int erv, input logic [DW-1:0] erd);
      exp_t e;
      ce = c;
      boot = b;
      if (eg == P0) begin
         e = '{cycle, 0, m0_if.rw, m0_if.adr, m0_if.wdata};
         gq.push_back(e);
      end else if (eg == P1) begin
         e = '{cycle, 1, m1_if.rw, m1_if.adr, m1_if.wdata};
         gq.push_back(e);
      end
      if (erv != NONE) begin
         e = '{cycle, erv - 1, 1'b0, '0, erd};
         rq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      // Requests during reset must be ignored.
      set0(1'b1, 1'b1, 1'b0, 6'd1, 16'h1111);
      set1(1'b1, 1'b0, 1'b0, 6'd2, 16'h0000);
      cyc(1, 0, NONE, NONE, 0);
      cyc(1, 0, NONE, NONE, 0);
      rst_n = 1'b1;

      // Preload through port 0.
      idle(); set0(1'b1, 1'b1, 1'b0, 6'd5, 16'h1234); cyc(1, 0, P0, NONE, 0);
      set0(1'b1, 1'b1, 1'b0, 6'd9, 16'h00A5);         cyc(1, 0, P0, NONE, 0);

      // Lone m1 read of adr 5.
      idle(); set1(1'b1, 1'b0, 1'b0, 6'd5, '0); cyc(1, 0, P1, NONE, 0);
      idle();                                   cyc(1, 0, NONE, P1, 16'h1234);

      // Both requesting, no lock: strict alternation starting with m0.
      set0(1'b1, 1'b1, 1'b0, 6'd10, 16'h00A0);
      set1(1'b1, 1'b1, 1'b0, 6'd11, 16'h00B1);
      cyc(1, 0, P0, NONE, 0);
      cyc(1, 0, P1, NONE, 0);
      cyc(1, 0, P0, NONE, 0);
      cyc(1, 0, P1, NONE, 0);
      idle(); set0(1'b1, 1'b0, 1'b0, 6'd10, '0); cyc(1, 0, P0, NONE, 0);
      idle();                                    cyc(1, 0, NONE, P0, 16'h00A0);

      // m1 locked burst against a waiting m0: 8 grants, then m0, repeating.
      set0(1'b1, 1'b1, 1'b0, 6'd13, 16'h0D0D);
      set1(1'b1, 1'b1, 1'b1, 6'd12, 16'h0C0C);
      for (int k = 0; k < 20; k++) cyc(1, 0, (k == 8 || k == 17) ? P0 : P1, NONE, 0);
      idle(); cyc(1, 0, NONE, NONE, 0);

      // Lone locked m1 saturates and keeps the RAM; released once m0 shows up.
      set1(1'b1, 1'b1, 1'b1, 6'd14, 16'h0E0E);
      for (int k = 0; k < 12; k++) cyc(1, 0, P1, NONE, 0);
      set0(1'b1, 1'b1, 1'b0, 6'd15, 16'h0F0F);
      cyc(1, 0, P1, NONE, 0);
      cyc(1, 0, P0, NONE, 0);
      idle(); cyc(1, 0, NONE, NONE, 0);

      // m1 read, then boot rises with an m0 write.
      set1(1'b1, 1'b0, 1'b0, 6'd5, '0); cyc(1, 0, P1, NONE, 0);
      set0(1'b1, 1'b1, 1'b0, 6'd3, 16'hBEEF);
      set1(1'b1, 1'b0, 1'b0, 6'd9, '0);
      cyc(1, 1, P0, P1, 16'h1234);
      set0(1'b1, 1'b0, 1'b1, 6'd3, '0);
      cyc(1, 1, P0, NONE, 0);
      set0(1'b0, 1'b0, 1'b0, '0, '0);
      set1(1'b1, 1'b0, 1'b1, 6'd9, '0);
      cyc(1, 1, NONE, P0, 16'hBEEF);

      // Boot falls with both requesting: boot rules this cycle, then m1 first.
      set0(1'b1, 1'b1, 1'b0, 6'd20, 16'h1111);
      set1(1'b1, 1'b1, 1'b0, 6'd21, 16'h2222);
      cyc(1, 0, P0, NONE, 0);
      cyc(1, 0, P1, NONE, 0);
      idle(); cyc(1, 0, NONE, NONE, 0);

      // ce dropped for 3 cycles after an m0 read grant.
      set0(1'b1, 1'b0, 1'b0, 6'd9, '0); cyc(1, 0, P0, NONE, 0);
      set0(1'b1, 1'b1, 1'b0, 6'd22, 16'h3333);
      set1(1'b1, 1'b1, 1'b0, 6'd23, 16'h4444);
      for (int k = 0; k < 3; k++) cyc(0, 0, NONE, NONE, 0);
      cyc(1, 0, P1, P0, 16'h00A5);
      idle(); cyc(1, 0, NONE, NONE, 0);

      // Async reset mid-lock drops the pending read return and resets prio.
      set1(1'b1, 1'b0, 1'b1, 6'd5, '0); cyc(1, 0, P1, NONE, 0);
      rst_n = 1'b0;
      set0(1'b1, 1'b1, 1'b0, 6'd24, 16'h5555);
      set1(1'b1, 1'b1, 1'b0, 6'd25, 16'h6666);
      cyc(1, 0, NONE, NONE, 0);
      rst_n = 1'b1;
      cyc(1, 0, P0, NONE, 0);
      cyc(1, 0, P1, NONE, 0);
      idle();
      cyc(1, 0, NONE, NONE, 0);
      cyc(1, 0, NONE, NONE, 0);

      checks++;
      if (gq.size() != 0) begin
         failures++;
         $display("FAIL grant_queue_drain actual=%0d required=0", gq.size());
      end
      checks++;
      if (rq.size() != 0) begin
         failures++;
         $display("FAIL rvalid_queue_drain actual=%0d required=0", rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
